// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC cascade/acknowledge controller.
//   pic_state_e  : acknowledge sequencer states
//   SPURIOUS_LVL : IR level reported when no request is pending at first INTA
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INTA1 = 2'd1,
        GAP   = 2'd2,
        INTA2 = 2'd3
    } pic_state_e;

    localparam logic [2:0] SPURIOUS_LVL = 3'd7;

endpackage

// File: rtl/pic_edge_det.sv
// Edge detector for the already-synchronised INTA strobe.
//   clk, rst : clock, synchronous active-high reset
//   sig      : level being watched
//   fall_c   : combinational pulse, sig 1 -> 0 this cycle
//   rise_c   : combinational pulse, sig 0 -> 1 this cycle
module pic_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic fall_c,
    output logic rise_c
);

    logic sig_q;

    // Previous value resets high so an idle-high strobe never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 1'b1;
        end else begin
            sig_q <= sig;
        end
    end

    assign fall_c = sig_q & ~sig;
    assign rise_c = ~sig_q & sig;

endmodule

// File: rtl/pic_cascade_ctrl.sv
// Interrupt-acknowledge sequencer with 8259-style cascade handling.
//   clk, rst      : clock, synchronous active-high reset
//   inta_n        : CPU acknowledge strobe (active low, synchronised)
//   sngl, master  : single-mode and cascade-master configuration
//   icw3          : master slave-present mask / slave ID in [2:0]
//   irq_level     : resolver's winning level, irq_pend: request pending
//   cas_in        : received CAS lines (slave)
//   cas_out/cas_oe: driven CAS lines and enable (master), decoded from state
//   isr_set       : registered pulse to set ISR[irq_level_lat]
//   irq_level_lat : level captured at the first INTA
//   data_oe       : vector byte enable during the second INTA, decoded
//   ack_done      : registered pulse on sequence completion
//   seq_err       : registered pulse on gap timeout
module pic_cascade_ctrl
    import pic_pkg::*;
#(
    parameter int unsigned GAP_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inta_n,
    input  logic       sngl,
    input  logic       master,
    input  logic [7:0] icw3,
    input  logic [2:0] irq_level,
    input  logic       irq_pend,
    input  logic [2:0] cas_in,
    output logic [2:0] cas_out,
    output logic       cas_oe,
    output logic       isr_set,
    output logic [2:0] irq_level_lat,
    output logic       data_oe,
    output logic       ack_done,
    output logic       seq_err
);

    localparam logic [CNT_W-1:0] GAP_LIMIT = CNT_W'(GAP_TIMEOUT);

    pic_state_e       state, state_nxt;
    logic [CNT_W-1:0] gap_cnt, gap_cnt_nxt;
    logic [2:0]       lat_nxt;
    logic             isr_set_nxt, ack_done_nxt, seq_err_nxt;
    logic             fall_c, rise_c;
    logic             casc_match_c, vec_sel_c;

    pic_edge_det u_edge (
        .clk    (clk),
        .rst    (rst),
        .sig    (inta_n),
        .fall_c (fall_c),
        .rise_c (rise_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            gap_cnt       <= '0;
            irq_level_lat <= 3'd0;
            isr_set       <= 1'b0;
            ack_done      <= 1'b0;
            seq_err       <= 1'b0;
        end else begin
            state         <= state_nxt;
            gap_cnt       <= gap_cnt_nxt;
            irq_level_lat <= lat_nxt;
            isr_set       <= isr_set_nxt;
            ack_done      <= ack_done_nxt;
            seq_err       <= seq_err_nxt;
        end
    end

    // Next-state logic. In GAP an INTA edge takes priority over the timeout.
    always_comb begin
        state_nxt    = state;
        gap_cnt_nxt  = gap_cnt;
        lat_nxt      = irq_level_lat;
        isr_set_nxt  = 1'b0;
        ack_done_nxt = 1'b0;
        seq_err_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall_c) begin
                    state_nxt = INTA1;
                    if (irq_pend) begin
                        lat_nxt     = irq_level;
                        isr_set_nxt = 1'b1;
                    end else begin
                        lat_nxt     = SPURIOUS_LVL;
                    end
                end
            end
            INTA1: begin
                if (rise_c) begin
                    state_nxt   = GAP;
                    gap_cnt_nxt = '0;
                end
            end
            GAP: begin
                if (fall_c) begin
                    state_nxt   = INTA2;
                end else if (gap_cnt == GAP_LIMIT) begin
                    state_nxt   = IDLE;
                    seq_err_nxt = 1'b1;
                end else begin
                    gap_cnt_nxt = gap_cnt + CNT_W'(1);
                end
            end
            INTA2: begin
                if (rise_c) begin
                    state_nxt    = IDLE;
                    ack_done_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus enables follow configuration combinationally so ICW changes act at once.
    always_comb begin
        casc_match_c = master & ~sngl & icw3[irq_level_lat];
        vec_sel_c    = sngl
                     | (master & ~icw3[irq_level_lat])
                     | (~master & (cas_in == icw3[2:0]));
        cas_oe       = (state != IDLE) & casc_match_c;
        cas_out      = cas_oe ? irq_level_lat : 3'd0;
        data_oe      = (state == INTA2) & ~inta_n & vec_sel_c;
    end

endmodule

// File: tb/tb_pic_cascade_ctrl.sv
// Directed bench for pic_cascade_ctrl: drives INTA pulse trains and counts
// output activity per sequence against hand-computed expectations.
module tb_pic_cascade_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       inta_n;
    logic       sngl;
    logic       master;
    logic [7:0] icw3;
    logic [2:0] irq_level;
    logic       irq_pend;
    logic [2:0] cas_in;
    logic [2:0] cas_out;
    logic       cas_oe;
    logic       isr_set;
    logic [2:0] irq_level_lat;
    logic       data_oe;
    logic       ack_done;
    logic       seq_err;

    int n_checks = 0;
    int n_fail   = 0;

    int n_isr, n_ack, n_err, n_doe, n_coe, n_casbad, n_doebad;
    logic [2:0] exp_lvl;

    pic_cascade_ctrl #(.GAP_TIMEOUT(15), .CNT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .inta_n        (inta_n),
        .sngl          (sngl),
        .master        (master),
        .icw3          (icw3),
        .irq_level     (irq_level),
        .irq_pend      (irq_pend),
        .cas_in        (cas_in),
        .cas_out       (cas_out),
        .cas_oe        (cas_oe),
        .isr_set       (isr_set),
        .irq_level_lat (irq_level_lat),
        .data_oe       (data_oe),
        .ack_done      (ack_done),
        .seq_err       (seq_err)
    );

    always #5 clk = ~clk;

    // Activity monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (isr_set)  n_isr++;
        if (ack_done) n_ack++;
        if (seq_err)  n_err++;
        if (data_oe)  n_doe++;
        if (cas_oe)   n_coe++;
        if (cas_oe && cas_out != exp_lvl) n_casbad++;
        if (!cas_oe && cas_out != 3'd0)   n_casbad++;
        if (data_oe && inta_n)            n_doebad++;
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        n_isr = 0; n_ack = 0; n_err = 0; n_doe = 0;
        n_coe = 0; n_casbad = 0; n_doebad = 0;
    endtask

    task automatic drive_cycles(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            inta_n = v;
        end
    endtask

    // First pulse low1 cycles, gap high cycles, optional second pulse, idle tail.
    task automatic inta_seq(input int low1, input int gap, input int low2);
        clear_mon();
        drive_cycles(1'b0, low1);
        drive_cycles(1'b1, gap);
        if (low2 > 0) begin
            drive_cycles(1'b0, low2);
            drive_cycles(1'b1, 3);
        end
    endtask

    task automatic set_cfg(input logic s, input logic m, input logic [7:0] w3,
                           input logic [2:0] lvl, input logic pend, input logic [2:0] ci);
        sngl = s; master = m; icw3 = w3; irq_level = lvl; irq_pend = pend; cas_in = ci;
        exp_lvl = lvl;
    endtask

    initial begin
        rst = 1'b1; inta_n = 1'b1;
        set_cfg(1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 3'd0);
        clear_mon();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cas_oe",  cas_oe, 0);
        check("rst_cas_out", cas_out, 0);
        check("rst_isr_set", isr_set, 0);
        check("rst_lat",     irq_level_lat, 0);
        check("rst_data_oe", data_oe, 0);
        check("rst_ack",     ack_done, 0);
        check("rst_err",     seq_err, 0);
        @(posedge clk); #1; rst = 1'b0;
        drive_cycles(1'b1, 2);

        // Master with slave on IR2: CAS driven for whole sequence, no vector.
        set_cfg(1'b0, 1'b1, 8'h04, 3'd2, 1'b1, 3'd0);
        inta_seq(2, 3, 3);
        check("mst_isr",    n_isr, 1);
        check("mst_ack",    n_ack, 1);
        check("mst_coe",    n_coe, 8);
        check("mst_casval", n_casbad, 0);
        check("mst_doe",    n_doe, 0);
        check("mst_err",    n_err, 0);
        check("mst_lat",    irq_level_lat, 2);

        // Master, no slave on IR3: vector from master itself.
        set_cfg(1'b0, 1'b1, 8'h04, 3'd3, 1'b1, 3'd0);
        inta_seq(2, 3, 3);
        check("mnos_coe", n_coe, 0);
        check("mnos_doe", n_doe, 2);
        check("mnos_ack", n_ack, 1);

        // Slave, CAS matches own ID.
        set_cfg(1'b0, 1'b0, 8'h05, 3'd1, 1'b1, 3'd5);
        inta_seq(2, 3, 3);
        check("slv_coe",   n_coe, 0);
        check("slv_doe",   n_doe, 2);
        check("slv_doewin", n_doebad, 0);
        check("slv_isr",   n_isr, 1);

        // Slave, CAS addresses another slave.
        set_cfg(1'b0, 1'b0, 8'h05, 3'd1, 1'b1, 3'd4);
        inta_seq(2, 3, 3);
        check("slvx_doe", n_doe, 0);
        check("slvx_ack", n_ack, 1);

        // Single mode overrides cascade configuration.
        set_cfg(1'b1, 1'b1, 8'hFF, 3'd6, 1'b1, 3'd0);
        inta_seq(2, 3, 3);
        check("sgl_lat", irq_level_lat, 6);
        check("sgl_coe", n_coe, 0);
        check("sgl_doe", n_doe, 2);

        // Spurious: nothing pending at first edge.
        set_cfg(1'b0, 1'b1, 8'h04, 3'd2, 1'b0, 3'd0);
        inta_seq(2, 3, 3);
        check("spu_lat", irq_level_lat, 7);
        check("spu_isr", n_isr, 0);
        check("spu_ack", n_ack, 1);

        // Second edge lands exactly on the timeout cycle: edge wins.
        set_cfg(1'b0, 1'b1, 8'h04, 3'd2, 1'b1, 3'd0);
        inta_seq(2, 16, 3);
        check("edge_err", n_err, 0);
        check("edge_ack", n_ack, 1);
        check("edge_coe", n_coe, 21);

        // Timeout: no second pulse.
        inta_seq(2, 20, 0);
        check("to_err", n_err, 1);
        check("to_ack", n_ack, 0);
        check("to_coe", n_coe, 18);
        @(negedge clk);
        check("to_idle_coe", cas_oe, 0);

        // Reset during GAP aborts silently, then a fresh sequence works.
        drive_cycles(1'b1, 2);
        clear_mon();
        drive_cycles(1'b0, 2);
        drive_cycles(1'b1, 3);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("mrst_coe", cas_oe, 0);
        check("mrst_cas", cas_out, 0);
        check("mrst_lat", irq_level_lat, 0);
        check("mrst_doe", data_oe, 0);
        clear_mon();
        drive_cycles(1'b1, 20);
        check("mrst_ack", n_ack, 0);
        check("mrst_err", n_err, 0);
        inta_seq(2, 3, 3);
        check("post_ack", n_ack, 1);
        check("post_isr", n_isr, 1);
        check("post_coe", n_coe, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
